e1b_code_writer: RTL
====================

Name: e1b_code_writer

Overview:
- Host-side loader for the E1B code BRAM (4k x GPS_CHANS, one code bit per channel per address).
- Loads or replaces one channel's E1B primary code while the other channels keep tracking.
- Takes 16-chip words from the eCPU, then does a read-modify-write of the selected channel's bit column on BRAM port A.
- The time-multiplexed channel reader on port B is unaffected.

Parameters:
- GPS_CHANS, 12, channels = BRAM data width.
- E1B_CODEBITS, 12, BRAM address width.
- E1B_CODELEN, 4092, chips per code.
- WORD_W, 16, chips per host word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load for ch_sel.
- ch_sel  in  clog2(GPS_CHANS)  channel to load; sampled on start.
- wr  in  1  host word strobe.
- tos  in  WORD_W  chips; bit0 = earliest chip.
- busy  out  1  word in progress; host must not assert wr.
- done  out  1  all E1B_CODELEN chips written (sticky).
- ovf  out  1  sticky: wr rejected (busy, idle or done).
- err  out  1  sticky: start with ch_sel >= GPS_CHANS.
- bram_addr  out  E1B_CODEBITS  port A address (registered).
- bram_din  out  GPS_CHANS  port A write data.
- bram_we  out  1  port A write enable.
- bram_dout  in  GPS_CHANS  port A read data; 1-cycle registered latency.

Behaviour:
- Reset state:
  - State IDLE.
  - busy, done, ovf, err, bram_we = 0; bram_addr = 0; bram_din = 0.
  - Chip counter = 0; shift register = 0.
- States: IDLE, WAIT, READ, MOD, DONE.
- IDLE/DONE + start, valid ch_sel:
  - Latch ch_sel; chip = 0.
  - Clear done and ovf; go to WAIT.
- Start with ch_sel >= GPS_CHANS: set err; state unchanged. err is cleared only by rst or a valid start.
- WAIT + wr:
  - Load tos into the shift register.
  - nbits = min(WORD_W, E1B_CODELEN - chip).
  - busy = 1 from the next cycle; go to READ.
- READ:
  - bram_addr = chip, bram_we = 0.
  - Next state MOD.
- MOD:
  - bram_dout is valid for bram_addr.
  - bram_din = bram_dout with bit[ch] replaced by shift[0]; all other bits pass unchanged.
  - bram_we = 1 for this single cycle, bram_addr held.
  - Then shift right by 1, chip += 1, nbits -= 1.
- Exit from MOD:
  - nbits now 0 and chip == E1B_CODELEN: go to DONE; done = 1, busy = 0.
  - nbits now 0 otherwise: go to WAIT; busy = 0.
  - Otherwise go to READ.
- Throughput: 2 cycles per chip; a full word keeps busy = 1 for 32 cycles.
  - Final word: 4092 = 255*16 + 12, so only tos[11:0] is used and tos[15:12] are ignored.
- wr while busy, in IDLE, or in DONE:
  - Word discarded, ovf = 1, no BRAM access.
  - In-progress write completes normally.
- start while busy (abort):
  - The current MOD write, if any, still completes that cycle.
  - Next cycle: restart at chip 0 in WAIT with the new ch_sel; ovf cleared; already-written chips are not rolled back.
- wr and start in the same cycle: start wins; the word is discarded and ovf is not set.
- rst mid-operation: immediate return to reset state. bram_we deasserts the same cycle, so no partial write follows rst.
- bram_addr never exceeds E1B_CODELEN-1.
- Port B reader races are benign: the write is single-bit-column, and other channels' bits are rewritten with their current values.

Test Plan:
- Reset, start ch_sel=3, 256 words of 0xFFFF -> 4092 writes, each bram_din = bram_dout | 0x008. done=1 after the last write; addresses 0..4091; ovf=0.
- BRAM pre-filled 0xFFF, load ch_sel=0 with 0xAAAA words -> address k bit0 = k&1. Bits 11:1 stay 1; bram_we 16 pulses per word; busy high 32 cycles.
- wr issued 5 cycles after the previous wr -> ovf=1, second word ignored. Chip counter advances only 16 per accepted word.
- Start ch_sel=12 -> err=1, no BRAM activity. Then start ch_sel=1 -> err=0, normal load.
- Mid-word start ch_sel=5 -> the in-flight MOD write completes, next cycle state=WAIT with chip=0. Subsequent writes target bit5.
- rst asserted during MOD -> bram_we=0 from that edge; busy, done, ovf = 0; bram_addr=0.

Source files
------------

// File: rtl/e1b_code_writer.sv
// e1b_code_writer: loads one channel's E1B primary code into the code BRAM.
// Each chip is a read-modify-write of one bit column on port A, 2 cycles/chip.
module e1b_code_writer #(
   parameter int GPS_CHANS    = 12,
   parameter int E1B_CODEBITS = 12,
   parameter int E1B_CODELEN  = 4092,
   parameter int WORD_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(GPS_CHANS)-1:0]  ch_sel,
   input  logic                          wr,
   input  logic [WORD_W-1:0]             tos,
   output logic                          busy,
   output logic                          done,
   output logic                          ovf,
   output logic                          err,
   output logic [E1B_CODEBITS-1:0]       bram_addr,
   output logic [GPS_CHANS-1:0]          bram_din,
   output logic                          bram_we,
   input  logic [GPS_CHANS-1:0]          bram_dout
);

   localparam int CH_W = $clog2(GPS_CHANS);
   localparam int NB_W = $clog2(WORD_W + 1);
   localparam logic [E1B_CODEBITS-1:0] LEN = E1B_CODEBITS'(E1B_CODELEN);
   localparam logic [E1B_CODEBITS-1:0] WCHIPS = E1B_CODEBITS'(WORD_W);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(GPS_CHANS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_MOD,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [E1B_CODEBITS-1:0] chip_q, chip_d;
   logic [E1B_CODEBITS-1:0] addr_q, addr_d;
   logic [NB_W-1:0]         nbits_q, nbits_d;
   logic [WORD_W-1:0]       shift_q, shift_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;
   logic                    err_q, err_d;

   logic [E1B_CODEBITS-1:0] remain;
   logic [E1B_CODEBITS-1:0] chip_nx;
   logic [NB_W-1:0]         nbits_word;
   logic                    start_ok;
   logic [GPS_CHANS-1:0]    col_mask;

   assign remain     = LEN - chip_q;
   assign chip_nx    = chip_q + E1B_CODEBITS'(1);
   assign nbits_word = (remain >= WCHIPS) ? NB_W'(WORD_W)
                                          : remain[NB_W-1:0];
   assign start_ok   = start && (ch_sel <= CH_LAST);
   assign col_mask   = GPS_CHANS'(1) << ch_q;

   assign busy      = (state_q == S_READ) || (state_q == S_MOD);
   assign bram_we   = (state_q == S_MOD);
   assign bram_addr = addr_q;
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

   // Write data: current BRAM word with only the selected channel bit replaced
   always_comb begin
      bram_din = '0;
      if (state_q == S_MOD) begin
         bram_din = (bram_dout & ~col_mask) | (shift_q[0] ? col_mask : '0);
      end
   end

   // Next-state logic: word intake, chip sequencing, start/abort and flags
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      chip_d  = chip_q;
      addr_d  = addr_q;
      nbits_d = nbits_q;
      shift_d = shift_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         S_WAIT: begin
            if (wr && !start) begin
               shift_d = tos;
               nbits_d = nbits_word;
               addr_d  = chip_q;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_MOD;
         end
         S_MOD: begin
            shift_d = shift_q >> 1;
            chip_d  = chip_nx;
            nbits_d = nbits_q - NB_W'(1);
            if (nbits_q == NB_W'(1)) begin
               if (chip_nx == LEN) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               addr_d  = chip_nx;
               state_d = S_READ;
            end
         end
         default: ;
      endcase
      if (wr && !start && (state_q != S_WAIT)) begin
         ovf_d = 1'b1;
      end
      if (start) begin
         if (start_ok) begin
            ch_d    = ch_sel;
            chip_d  = '0;
            addr_d  = '0;
            nbits_d = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            state_d = S_WAIT;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         chip_q  <= '0;
         addr_q  <= '0;
         nbits_q <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         chip_q  <= chip_d;
         addr_q  <= addr_d;
         nbits_q <= nbits_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

endmodule
